int_service_seq: RTL and testbench

CPU-side responder to the interrupt controller's 5-bit request vector. At instruction boundaries it selects the winning source by 8051 two-level priority, pushes the return PC through a stack handshake, and loads the vector address. It clears the serviced TCON edge/overflow flag and tracks in-service levels until RETI. It sits between the interrupt controller and the CPU fetch/stack logic.

---
 rtl/int_service_seq.sv | 160 ++++++++++++++++
 tb/tb_int_service_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_service_seq.sv
// Interrupt service sequencer: picks the winning request at an instruction boundary, pushes the return PC, loads the vector.
// Latency: take on instr_end at N -> pushes at N+1/N+2 (ack tied high) -> pc_load at N+3 -> idle at N+4.
// Backpressure: each push byte waits on push_ack; busy stalls CPU fetch. INT_NEST_EN enables two-level priority nesting.
module int_service_seq #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int          VEC_STRIDE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  int_req,
  input  logic        ea,
  input  logic [4:0]  ip,
  input  logic        instr_end,
  input  logic        reti,
  input  logic [15:0] pc_in,
  input  logic        push_ack,
  output logic        busy,
  output logic        push_req,
  output logic [7:0]  push_data,
  output logic        pc_load,
  output logic [15:0] pc_vec,
  output logic [3:0]  flag_clr,
  output logic [1:0]  in_service
);

  typedef enum logic [1:0] {IDLE, PUSH_L, PUSH_H, JUMP} state_t;

  localparam logic [15:0] STRIDE16 = 16'(VEC_STRIDE);

  state_t      state_q;
  logic [2:0]  src_q;
  logic [15:0] pc_q;
  logic        hi_q;
  logic        hold_q;
  logic [1:0]  in_service_q;
  logic        busy_q;
  logic        push_req_q;
  logic [7:0]  push_data_q;
  logic        pc_load_q;
  logic [15:0] pc_vec_q;
  logic [3:0]  flag_clr_q;

  logic [4:0]  allowed_hi;
  logic [4:0]  allowed_lo;
  logic        win_hi;
  logic [2:0]  win_src;
  logic        take;
  logic [15:0] vec_d;
  logic [3:0]  flag_d;

  // Lowest set bit index of a request vector (0 when empty).
  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

`ifndef INT_NEST_EN
  // ip has no meaning when every source is low priority.
  logic unused_ip;
  assign unused_ip = ^ip;
`endif

  // Request arbitration: which requests may interrupt, and who wins.
  always_comb begin
    allowed_hi = '0;
    allowed_lo = '0;
`ifdef INT_NEST_EN
    if (!in_service_q[1]) allowed_hi = int_req & ip;
    if (in_service_q == 2'b00) allowed_lo = int_req & ~ip;
`else
    if (in_service_q == 2'b00) allowed_lo = int_req;
`endif
    win_hi  = |allowed_hi;
    win_src = win_hi ? lowest_idx(allowed_hi) : lowest_idx(allowed_lo);
    take    = (state_q == IDLE) && instr_end && !reti && ea && !hold_q &&
              ((|allowed_hi) || (|allowed_lo));
  end

  // Vector address and TCON flag clear derived from the latched source.
  always_comb begin
    vec_d  = VEC_BASE + STRIDE16 * {13'd0, src_q};
    flag_d = src_q[2] ? 4'b0000 : (4'b0001 << src_q[1:0]);
  end

  // Service FSM with registered outputs, in-service tracking and post-RETI hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      pc_q         <= '0;
      hi_q         <= 1'b0;
      hold_q       <= 1'b0;
      in_service_q <= '0;
      busy_q       <= 1'b0;
      push_req_q   <= 1'b0;
      push_data_q  <= '0;
      pc_load_q    <= 1'b0;
      pc_vec_q     <= '0;
      flag_clr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reti) begin
            // RETI closes the most recent level; one instruction must run before the next take.
            hold_q <= 1'b1;
            if (in_service_q[1]) in_service_q[1] <= 1'b0;
            else                 in_service_q[0] <= 1'b0;
          end else if (instr_end && hold_q) begin
            hold_q <= 1'b0;
          end else if (take) begin
            src_q       <= win_src;
            pc_q        <= pc_in;
            hi_q        <= win_hi;
            state_q     <= PUSH_L;
            busy_q      <= 1'b1;
            push_req_q  <= 1'b1;
            push_data_q <= pc_in[7:0];
          end
        end
        PUSH_L: begin
          if (push_ack) begin
            state_q     <= PUSH_H;
            push_data_q <= pc_q[15:8];
          end
        end
        PUSH_H: begin
          if (push_ack) begin
            state_q    <= JUMP;
            push_req_q <= 1'b0;
            pc_load_q  <= 1'b1;
            pc_vec_q   <= vec_d;
            flag_clr_q <= flag_d;
          end
        end
        JUMP: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          pc_load_q  <= 1'b0;
          flag_clr_q <= '0;
          if (hi_q) in_service_q[1] <= 1'b1;
          else      in_service_q[0] <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign push_req   = push_req_q;
  assign push_data  = push_data_q;
  assign pc_load    = pc_load_q;
  assign pc_vec     = pc_vec_q;
  assign flag_clr   = flag_clr_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_service_seq.sv
// Directed bench for int_service_seq: vector table of single takes plus nesting, hold, stall and reset sequences.
// Expected values track the INT_NEST_EN build option.
// All stimulus changes 1ns after the rising edge; outputs are sampled at the same point.
module tb_int_service_seq;

  logic        clk;
  logic        rst_n;
  logic [4:0]  int_req;
  logic        ea;
  logic [4:0]  ip;
  logic        instr_end;
  logic        reti;
  logic [15:0] pc_in;
  logic        push_ack;
  logic        busy;
  logic        push_req;
  logic [7:0]  push_data;
  logic        pc_load;
  logic [15:0] pc_vec;
  logic [3:0]  flag_clr;
  logic [1:0]  in_service;

  int n_total = 0;
  int n_pass  = 0;

  int_service_seq dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .ea(ea), .ip(ip),
    .instr_end(instr_end), .reti(reti), .pc_in(pc_in), .push_ack(push_ack),
    .busy(busy), .push_req(push_req), .push_data(push_data), .pc_load(pc_load),
    .pc_vec(pc_vec), .flag_clr(flag_clr), .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  req;
    logic [4:0]  ipv;
    logic [15:0] pc;
    logic [15:0] vec;
    logic [3:0]  flag;
    logic [1:0]  is;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; int_req = '0; ea = 1'b0; ip = '0; instr_end = 1'b0;
    reti = 1'b0; pc_in = '0; push_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Full take with push_ack high; checks every cycle of the sequence.
  task automatic run_take(input string name, input logic [4:0] req, input logic [4:0] ipv,
                          input logic [15:0] pc, input logic [15:0] exp_vec,
                          input logic [3:0] exp_flag, input logic [1:0] exp_is);
    ea = 1'b1; ip = ipv; int_req = req; pc_in = pc; push_ack = 1'b1; instr_end = 1'b1;
    step();
    instr_end = 1'b0; int_req = '0;
    check({name, "/L_busy"}, 32'(busy), 32'd1);
    check({name, "/L_req"}, 32'(push_req), 32'd1);
    check({name, "/L_data"}, 32'(push_data), 32'(pc[7:0]));
    step();
    check({name, "/H_data"}, 32'(push_data), 32'(pc[15:8]));
    check({name, "/H_load"}, 32'(pc_load), 32'd0);
    step();
    check({name, "/J_load"}, 32'(pc_load), 32'd1);
    check({name, "/J_vec"}, 32'(pc_vec), 32'(exp_vec));
    check({name, "/J_flag"}, 32'(flag_clr), 32'(exp_flag));
    check({name, "/J_req"}, 32'(push_req), 32'd0);
    step();
    check({name, "/E_busy"}, 32'(busy), 32'd0);
    check({name, "/E_is"}, 32'(in_service), 32'(exp_is));
    check({name, "/E_flag"}, 32'(flag_clr), 32'd0);
    check({name, "/E_vec"}, 32'(pc_vec), 32'(exp_vec));
  endtask

  // instr_end with a request that must not be taken.
  task automatic no_take(input string name, input logic [4:0] req, input logic [4:0] ipv);
    ea = 1'b1; ip = ipv; int_req = req; instr_end = 1'b1;
    step();
    instr_end = 1'b0;
    check({name, "/busy"}, 32'(busy), 32'd0);
    check({name, "/req"}, 32'(push_req), 32'd0);
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef INT_NEST_EN
    tbl[0] = '{5'b00010, 5'b00000, 16'h1234, 16'h000B, 4'b0010, 2'b01};
    tbl[1] = '{5'b10001, 5'b10000, 16'hABCD, 16'h0023, 4'b0000, 2'b10};
    tbl[2] = '{5'b01100, 5'b00000, 16'h5678, 16'h0013, 4'b0100, 2'b01};
    tbl[3] = '{5'b01000, 5'b01000, 16'h0F0E, 16'h001B, 4'b1000, 2'b10};
    tbl[4] = '{5'b10000, 5'b00000, 16'hFFFF, 16'h0023, 4'b0000, 2'b01};
    tbl[5] = '{5'b11111, 5'b00110, 16'h8001, 16'h000B, 4'b0010, 2'b10};
`else
    tbl[0] = '{5'b00010, 5'b00000, 16'h1234, 16'h000B, 4'b0010, 2'b01};
    tbl[1] = '{5'b10001, 5'b10000, 16'hABCD, 16'h0003, 4'b0001, 2'b01};
    tbl[2] = '{5'b01100, 5'b00000, 16'h5678, 16'h0013, 4'b0100, 2'b01};
    tbl[3] = '{5'b01000, 5'b01000, 16'h0F0E, 16'h001B, 4'b1000, 2'b01};
    tbl[4] = '{5'b10000, 5'b00000, 16'hFFFF, 16'h0023, 4'b0000, 2'b01};
    tbl[5] = '{5'b11111, 5'b00110, 16'h8001, 16'h0003, 4'b0001, 2'b01};
`endif

    // Reset state
    do_reset();
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/push_req", 32'(push_req), 32'd0);
    check("rst/push_data", 32'(push_data), 32'd0);
    check("rst/pc_load", 32'(pc_load), 32'd0);
    check("rst/pc_vec", 32'(pc_vec), 32'd0);
    check("rst/flag_clr", 32'(flag_clr), 32'd0);
    check("rst/in_service", 32'(in_service), 32'd0);

    // ea low blocks takes
    ea = 1'b0; int_req = 5'b00001; instr_end = 1'b1;
    step();
    instr_end = 1'b0;
    check("ea_off/busy", 32'(busy), 32'd0);

    // Table of single takes from reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_take($sformatf("tbl%0d", i), tbl[i].req, tbl[i].ipv, tbl[i].pc,
               tbl[i].vec, tbl[i].flag, tbl[i].is);
    end

    // Nesting, RETI and hold
    do_reset();
    run_take("nest_lo", 5'b00001, 5'b00000, 16'h1000, 16'h0003, 4'b0001, 2'b01);
    no_take("nest_lo_blocked", 5'b00100, 5'b00000);
`ifdef INT_NEST_EN
    run_take("nest_hi", 5'b00100, 5'b00100, 16'h2000, 16'h0013, 4'b0100, 2'b11);
    pulse_reti();
    check("reti1/is", 32'(in_service), 32'd1);
    pulse_reti();
    check("reti2/is", 32'(in_service), 32'd0);
`else
    no_take("nest_hi_blocked", 5'b00100, 5'b00100);
    pulse_reti();
    check("reti1/is", 32'(in_service), 32'd0);
`endif
    no_take("hold", 5'b00001, 5'b00000);
    run_take("after_hold", 5'b00001, 5'b00000, 16'h3000, 16'h0003, 4'b0001, 2'b01);

    // reti together with instr_end: reti wins, then hold swallows the next boundary
    ea = 1'b1; ip = '0; int_req = 5'b00001; reti = 1'b1; instr_end = 1'b1;
    step();
    reti = 1'b0; instr_end = 1'b0;
    check("reti_ie/busy", 32'(busy), 32'd0);
    check("reti_ie/is", 32'(in_service), 32'd0);
    no_take("reti_ie_hold", 5'b00001, 5'b00000);
    run_take("reti_ie_take", 5'b00001, 5'b00000, 16'h4000, 16'h0003, 4'b0001, 2'b01);

    // push_ack stall in PUSH_L with request withdrawn
    begin
      bit seen;
      do_reset();
      ea = 1'b1; ip = '0; int_req = 5'b00010; pc_in = 16'h1234; push_ack = 1'b0; instr_end = 1'b1;
      step();
      instr_end = 1'b0; int_req = '0; ea = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("stall%0d/data", k), 32'(push_data), 32'h34);
        check($sformatf("stall%0d/busy", k), 32'(busy), 32'd1);
        check($sformatf("stall%0d/req", k), 32'(push_req), 32'd1);
        if (k < 2) step();
      end
      push_ack = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step();
        if (pc_load) seen = 1'b1;
      end
      check("stall/pc_load_seen", 32'(seen), 32'd1);
      check("stall/pc_vec", 32'(pc_vec), 32'h000B);
      check("stall/flag", 32'(flag_clr), 32'b0010);
    end

    // Async reset while in PUSH_H
    do_reset();
    ea = 1'b1; ip = '0; int_req = 5'b00010; pc_in = 16'h1234; push_ack = 1'b1; instr_end = 1'b1;
    step();
    instr_end = 1'b0;
    step();
    check("rstH/pre_data", 32'(push_data), 32'h12);
    rst_n = 1'b0;
    #1;
    check("rstH/busy", 32'(busy), 32'd0);
    check("rstH/push_req", 32'(push_req), 32'd0);
    check("rstH/push_data", 32'(push_data), 32'd0);
    check("rstH/pc_load", 32'(pc_load), 32'd0);
    check("rstH/pc_vec", 32'(pc_vec), 32'd0);
    check("rstH/flag", 32'(flag_clr), 32'd0);
    int_req = '0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rstH/after_busy", 32'(busy), 32'd0);
    check("rstH/after_is", 32'(in_service), 32'd0);
    check("rstH/after_load", 32'(pc_load), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
